mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register.
//  Runs lw/lb/lbu/sw/sb against a handshaked data-memory port and stalls upstream while the access is outstanding.
//  Extracts, extends and selects write-back data (load / ALU / link).
//  Holds the MEM/WB pipeline register that feeds register-file write-back.
// PARAMETERS
//  TIMEOUT      16  max BUSY cycles waiting for dm_ack before abort (>=2)
//  LINK_OFFSET  4   added to instru_memAddress for link write-back value
// PORTS
//  clk                input   1   pipeline clock, rising edge
//  regReset           input   1   reset, asynchronous, active-low
//  mem2Reg_mem        input   1   load instruction (lw/lb/lbu)
//  regWr_mem          input   1   instruction writes register file
//  memWr_mem          input   1   store instruction (sw/sb)
//  lb_mem             input   1   byte load, sign-extend
//  lbu_mem            input   1   byte load, zero-extend
//  sb_mem             input   1   byte store
//  link_mem           input   1   link write (jal/bgezal etc.)
//  aluResult_mem      input   32  effective address / ALU result
//  busB_mem           input   32  store data
//  rw_mem             input   5   destination register
//  instru_memAddress  input   32  instruction address
//  dm_req             output  1   memory request, held until dm_ack
//  dm_we              output  1   1 = write
//  dm_be              output  4   byte enables
//  dm_addr            output  32  word address {aluResult_mem[31:2],2'b00}
//  dm_wdata           output  32  write data
//  dm_rdata           input   32  read data, valid with dm_ack
//  dm_ack             input   1   memory completes request this cycle
//  mem_stall          output  1   freeze PC/IF/ID/EX/MEM regs this cycle
//  dm_err             output  1   sticky: misaligned or timeout occurred
//  regWr_wb           output  1   MEM/WB: write enable
//  rw_wb              output  5   MEM/WB: destination register
//  busW_wb            output  32  MEM/WB: write-back data
// BEHAVIOUR
//  - access = mem2Reg_mem | memWr_mem. Byte op = lb|lbu|sb, else word.
//  - Misaligned: word op with aluResult_mem[1:0]!=0. No request issued, no stall.
//    Set dm_err; regWr_wb<=0 for that instruction.
//  - FSM IDLE/BUSY/DONE. Reset: IDLE, counter 0, all outputs 0 (async).
//  - IDLE: aligned access -> BUSY, mem_stall=1. Otherwise stall=0.
//  - BUSY: dm_req=1, mem_stall=1, counter++. Address/data/be are driven from inputs (held by the stall).
//    - dm_ack: capture dm_rdata into rdata_q -> DONE.
//    - counter==TIMEOUT-1 without ack: dm_err=1, rdata_q=0 -> DONE.
//  - DONE: dm_req=0, mem_stall=0; MEM/WB captures the instruction -> IDLE. Counter cleared.
//  - Latency: aligned access with ack on first BUSY cycle = 3 cycles in MEM (IDLE, BUSY, DONE).
//    Non-memory instruction = 1 cycle.
//  - dm_we=memWr_mem. sw: be=4'b1111, wdata=busB_mem.
//    sb: be=4'b0001<<addr[1:0], wdata={4{busB_mem[7:0]}}.
//    Loads: be=4'b1111.
//  - Load lane byte=rdata_q[8*addr[1:0]+:8]. lb sign-extends, lbu zero-extends, lw uses full word.
//  - busW select, priority: link -> instru_memAddress+LINK_OFFSET (mod 2^32);
//    mem2Reg -> load data; else aluResult_mem.
//  - MEM/WB update every clk. When mem_stall=1, load bubble (regWr_wb=0, rw_wb=0, busW_wb=0) so no write repeats.
//    Else load regWr_mem (masked if misaligned), rw_mem, busW.
//  - dm_ack outside BUSY is ignored. dm_err clears only on reset.
//  - Reset mid-BUSY: dm_req and mem_stall drop immediately; the transaction is abandoned.
// TESTING
//  - add, aluResult=0x00000123, rw=5, no access -> next edge regWr_wb=1, rw_wb=5, busW_wb=0x123, stall never high.
//  - lb addr 0x1002, dm_rdata=0x12F45678, ack 2nd BUSY cycle -> stall 3 cycles, busW_wb=0xFFFFFFF4; lbu same -> 0x000000F4.
//  - sb addr 0x2003, busB=0xAABBCC7E -> dm_be=4'b1000, dm_wdata=0x7E7E7E7E, dm_we=1, regWr_wb=0.
//  - lw addr 0x0006 -> dm_req never asserts, dm_err=1, regWr_wb=0, no stall.
//  - lw, dm_ack held low -> stall exactly TIMEOUT+1 cycles, dm_err=1, busW_wb=0.
//  - jal, instru_memAddress=0x00400010 -> busW_wb=0x00400014. Async reset asserted mid-BUSY -> dm_req=0 same cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory access (lw/lb/lbu/sw/sb), load extraction and MEM/WB register.
// Latency: 1 cycle for non-memory ops; memory ops take IDLE + N BUSY + DONE cycles.
// Backpressure: mem_stall freezes upstream until dm_ack or timeout; stalled cycles load a bubble.
module mem_access_stage #(
  parameter int          TIMEOUT     = 16,
  parameter logic [31:0] LINK_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        regReset,
  input  logic        mem2Reg_mem,
  input  logic        regWr_mem,
  input  logic        memWr_mem,
  input  logic        lb_mem,
  input  logic        lbu_mem,
  input  logic        sb_mem,
  input  logic        link_mem,
  input  logic [31:0] aluResult_mem,
  input  logic [31:0] busB_mem,
  input  logic [4:0]  rw_mem,
  input  logic [31:0] instru_memAddress,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_stall,
  output logic        dm_err,
  output logic        regWr_wb,
  output logic [4:0]  rw_wb,
  output logic [31:0] busW_wb
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          regwr_wb_q, regwr_wb_d;
  logic [4:0]    rw_wb_q, rw_wb_d;
  logic [31:0]   busw_wb_q, busw_wb_d;

  logic        access, byte_op, misaligned, aligned_acc;
  logic        stall, req, busy;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [7:0]  lane;
  logic [31:0] load_data, busw;

  // Decode the access type and build byte enables / write data for the port
  always_comb begin
    access      = mem2Reg_mem | memWr_mem;
    byte_op     = lb_mem | lbu_mem | sb_mem;
    misaligned  = access & ~byte_op & (aluResult_mem[1:0] != 2'b00);
    aligned_acc = access & ~misaligned;
    be_w        = sb_mem ? (4'b0001 << aluResult_mem[1:0]) : 4'b1111;
    wdata_w     = sb_mem ? {4{busB_mem[7:0]}} : busB_mem;
  end

  // Access sequencer: next state, timeout counter, captured read data, sticky error
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall   = 1'b0;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (aligned_acc) begin
          stall   = 1'b1;
          state_d = BUSY;
        end else if (misaligned) begin
          err_d = 1'b1;
        end
      end
      BUSY: begin
        req   = 1'b1;
        stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (dm_ack) begin
          rdata_d = dm_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Pick the addressed byte lane and extend it, then select write-back data
  always_comb begin
    case (aluResult_mem[1:0])
      2'd0:    lane = rdata_q[7:0];
      2'd1:    lane = rdata_q[15:8];
      2'd2:    lane = rdata_q[23:16];
      default: lane = rdata_q[31:24];
    endcase
    if (lb_mem)       load_data = {{24{lane[7]}}, lane};
    else if (lbu_mem) load_data = {24'h0, lane};
    else              load_data = rdata_q;
    if (link_mem)         busw = instru_memAddress + LINK_OFFSET;
    else if (mem2Reg_mem) busw = load_data;
    else                  busw = aluResult_mem;
  end

  // MEM/WB next value: bubble while stalled so a held instruction writes back once
  always_comb begin
    regwr_wb_d = 1'b0;
    rw_wb_d    = '0;
    busw_wb_d  = '0;
    if (!stall) begin
      regwr_wb_d = regWr_mem & ~misaligned;
      rw_wb_d    = rw_mem;
      busw_wb_d  = busw;
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge regReset) begin
    if (!regReset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      regwr_wb_q <= 1'b0;
      rw_wb_q    <= '0;
      busw_wb_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      regwr_wb_q <= regwr_wb_d;
      rw_wb_q    <= rw_wb_d;
      busw_wb_q  <= busw_wb_d;
    end
  end

  // Port drive: request fields only while BUSY; reset forces handshake and stall low at once
  always_comb begin
    busy      = (state_q == BUSY);
    dm_req    = req & regReset;
    mem_stall = stall & regReset;
    dm_we     = busy & memWr_mem;
    dm_be     = busy ? be_w : 4'b0000;
    dm_addr   = busy ? {aluResult_mem[31:2], 2'b00} : 32'h0;
    dm_wdata  = busy ? wdata_w : 32'h0;
    dm_err    = err_q;
    regWr_wb  = regwr_wb_q;
    rw_wb     = rw_wb_q;
    busW_wb   = busw_wb_q;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int TIMEOUT = 16;
  localparam int OP_ALU = 0, OP_LW = 1, OP_LB = 2, OP_LBU = 3, OP_SW = 4, OP_SB = 5, OP_JAL = 6;

  logic        clk = 1'b0;
  logic        regReset;
  logic        mem2Reg_mem, regWr_mem, memWr_mem, lb_mem, lbu_mem, sb_mem, link_mem;
  logic [31:0] aluResult_mem, busB_mem, instru_memAddress;
  logic [4:0]  rw_mem;
  logic        dm_req, dm_we, dm_ack, mem_stall, dm_err, regWr_wb;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, busW_wb;
  logic [4:0]  rw_wb;

  int vectors = 0;
  int miscompares = 0;
  bit model_err = 1'b0;

  mem_access_stage dut (
    .clk(clk), .regReset(regReset),
    .mem2Reg_mem(mem2Reg_mem), .regWr_mem(regWr_mem), .memWr_mem(memWr_mem),
    .lb_mem(lb_mem), .lbu_mem(lbu_mem), .sb_mem(sb_mem), .link_mem(link_mem),
    .aluResult_mem(aluResult_mem), .busB_mem(busB_mem), .rw_mem(rw_mem),
    .instru_memAddress(instru_memAddress),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mem_stall(mem_stall), .dm_err(dm_err),
    .regWr_wb(regWr_wb), .rw_wb(rw_wb), .busW_wb(busW_wb)
  );

  always #5 clk = ~clk;

  task automatic drive_op(input int op, input logic [31:0] addr, input logic [31:0] bdata,
                          input logic [4:0] rw, input logic [31:0] pc);
    mem2Reg_mem       = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    memWr_mem         = (op == OP_SW) || (op == OP_SB);
    lb_mem            = (op == OP_LB);
    lbu_mem           = (op == OP_LBU);
    sb_mem            = (op == OP_SB);
    link_mem          = (op == OP_JAL);
    regWr_mem         = !memWr_mem;
    aluResult_mem     = addr;
    busB_mem          = bdata;
    rw_mem            = rw;
    instru_memAddress = pc;
  endtask

  // One instruction through MEM. ack_at = BUSY cycle on which memory acks (0 = never).
  task automatic apply(input string name, input int op, input logic [31:0] addr,
                       input logic [31:0] bdata, input logic [4:0] rw, input logic [31:0] pc,
                       input logic [31:0] rdata, input int ack_at, input bit spurious);
    bit is_load, is_store, is_byte, mis, aligned, tmo, done, prev_stall;
    int exp_busy, exp_stall, stalls, busy;
    logic [31:0] word, exp_busw;
    logic [7:0]  b;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    bit exp_regwr;

    // Reference model: what this instruction should do, from the ISA-level rules
    is_load   = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    is_store  = (op == OP_SW) || (op == OP_SB);
    is_byte   = (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    mis       = (is_load || is_store) && !is_byte && (addr % 4 != 0);
    aligned   = (is_load || is_store) && !mis;
    tmo       = aligned && (ack_at < 1 || ack_at > TIMEOUT);
    exp_busy  = !aligned ? 0 : (tmo ? TIMEOUT : ack_at);
    exp_stall = aligned ? exp_busy + 1 : 0;
    word      = tmo ? 32'h0 : rdata;
    b         = 8'((word >> (8 * (addr % 4))) & 32'hFF);
    if (op == OP_JAL)     exp_busw = pc + 32'd4;
    else if (op == OP_LB) exp_busw = {{24{b[7]}}, b};
    else if (op == OP_LBU) exp_busw = {24'h0, b};
    else if (op == OP_LW) exp_busw = word;
    else                  exp_busw = addr;
    exp_regwr = !is_store && !mis;
    exp_be    = (op == OP_SB) ? 4'(1 << (addr % 4)) : 4'hF;
    exp_wdata = (op == OP_SB) ? {4{bdata[7:0]}} : bdata;
    if (mis || tmo) model_err = 1'b1;

    drive_op(op, addr, bdata, rw, pc);
    dm_rdata = rdata;
    dm_ack   = spurious && !(is_load || is_store);
    stalls = 0; busy = 0; prev_stall = 0; done = 0;
    for (int cyc = 0; cyc < TIMEOUT + 8 && !done; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        vectors++;
        if (regWr_wb !== 1'b0 || rw_wb !== 5'd0 || busW_wb !== 32'h0) begin
          miscompares++;
          $display("FAIL %s bubble: got regWr=%b rw=%0d busW=%h, want 0/0/0", name, regWr_wb, rw_wb, busW_wb);
        end
      end
      if (dm_req) begin
        busy++;
        if (busy == 1) begin
          vectors++;
          if (dm_we !== is_store || dm_be !== exp_be || dm_addr !== {addr[31:2], 2'b00} ||
              (is_store && dm_wdata !== exp_wdata)) begin
            miscompares++;
            $display("FAIL %s port: got we=%b be=%b addr=%h wdata=%h, want we=%b be=%b addr=%h wdata=%h",
                     name, dm_we, dm_be, dm_addr, dm_wdata, is_store, exp_be, {addr[31:2], 2'b00}, exp_wdata);
          end
        end
        dm_ack = (busy == ack_at);
      end else begin
        dm_ack = (is_load || is_store) ? 1'b0 : spurious;
      end
      if (mem_stall) stalls++;
      prev_stall = mem_stall;
      if (!mem_stall) done = 1;
      @(posedge clk);
      #1;
    end
    dm_ack = 1'b0;

    vectors++;
    if (!done || stalls != exp_stall || busy != exp_busy) begin
      miscompares++;
      $display("FAIL %s timing: got done=%0d stalls=%0d busy=%0d, want stalls=%0d busy=%0d",
               name, done, stalls, busy, exp_stall, exp_busy);
    end
    vectors++;
    if (regWr_wb !== exp_regwr || rw_wb !== rw ||
        (!(mis && is_load) && busW_wb !== exp_busw)) begin
      miscompares++;
      $display("FAIL %s writeback: got regWr=%b rw=%0d busW=%h, want regWr=%b rw=%0d busW=%h",
               name, regWr_wb, rw_wb, busW_wb, exp_regwr, rw, exp_busw);
    end
    vectors++;
    if (dm_err !== model_err) begin
      miscompares++;
      $display("FAIL %s dm_err: got %b want %b", name, dm_err, model_err);
    end
  endtask

  task automatic test_reset();
    regReset = 1'b0;
    drive_op(OP_LW, 32'h100, 32'h0, 5'd1, 32'h0);
    dm_ack = 1'b0; dm_rdata = 32'h0;
    #12;
    vectors++;
    if (dm_req !== 1'b0 || mem_stall !== 1'b0 || dm_err !== 1'b0 || regWr_wb !== 1'b0 ||
        rw_wb !== 5'd0 || busW_wb !== 32'h0 || dm_be !== 4'h0 || dm_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got req=%b stall=%b err=%b regWr=%b rw=%0d busW=%h be=%b we=%b, want all 0",
               dm_req, mem_stall, dm_err, regWr_wb, rw_wb, busW_wb, dm_be, dm_we);
    end
    drive_op(OP_ALU, 32'h0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    regReset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    apply("add", OP_ALU, 32'h00000123, 32'h0, 5'd5, 32'h0, 32'h0, 0, 1'b1);
  endtask

  task automatic test_byte_loads();
    apply("lb", OP_LB, 32'h00001002, 32'h0, 5'd7, 32'h0, 32'h12F45678, 2, 1'b0);
    apply("lbu", OP_LBU, 32'h00001002, 32'h0, 5'd8, 32'h0, 32'h12F45678, 2, 1'b0);
    apply("lw", OP_LW, 32'h00001004, 32'h0, 5'd9, 32'h0, 32'hCAFEBABE, 1, 1'b0);
  endtask

  task automatic test_byte_store();
    apply("sb", OP_SB, 32'h00002003, 32'hAABBCC7E, 5'd3, 32'h0, 32'h0, 1, 1'b0);
    apply("sw", OP_SW, 32'h00002008, 32'h01234567, 5'd4, 32'h0, 32'h0, 3, 1'b0);
  endtask

  task automatic test_link();
    apply("jal", OP_JAL, 32'h0000BEEF, 32'h0, 5'd31, 32'h00400010, 32'h0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      apply("b2b_alu", OP_ALU, $urandom, 32'h0, 5'(i + 10), 32'h0, 32'h0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int op, r, ack_at;
      logic [31:0] addr;
      op   = $urandom_range(0, 6);
      addr = $urandom;
      if ((op == OP_LW || op == OP_SW) && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      if (r < 7)       ack_at = $urandom_range(1, 3);
      else if (r == 7) ack_at = 0;
      else if (r == 8) ack_at = TIMEOUT;
      else             ack_at = $urandom_range(4, TIMEOUT);
      apply("random", op, addr, $urandom, 5'($urandom), $urandom, $urandom, ack_at, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_busy();
    drive_op(OP_LW, 32'h00000040, 32'h0, 5'd2, 32'h0);
    dm_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    @(negedge clk);
    vectors++;
    if (dm_req !== 1'b1 || mem_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL midbusy_pre: got req=%b stall=%b, want 1/1", dm_req, mem_stall);
    end
    regReset = 1'b0;
    #1;
    vectors++;
    if (dm_req !== 1'b0 || mem_stall !== 1'b0 || dm_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midbusy_reset: got req=%b stall=%b err=%b, want 0/0/0", dm_req, mem_stall, dm_err);
    end
    model_err = 1'b0;
    drive_op(OP_ALU, 32'h0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    regReset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    apply("misaligned_lw", OP_LW, 32'h00000006, 32'h0, 5'd6, 32'h0, 32'h11223344, 1, 1'b0);
  endtask

  task automatic test_timeout();
    apply("timeout_lw", OP_LW, 32'h00000010, 32'h0, 5'd12, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    apply("ack_last", OP_LW, 32'h00000014, 32'h0, 5'd13, 32'h0, 32'h5A5A1234, TIMEOUT, 1'b0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_byte_loads();
    test_byte_store();
    test_link();
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
    test_alu();
    test_misaligned();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
